// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one AXI-Stream UART TX path between
// N_PORTS byte-stream requesters. A grant is held until tlast or a burst-limit release.
module axis_uart_tx_arbiter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned N_PORTS     = 4,
    parameter int unsigned MAX_BURST   = 64,
    localparam int unsigned IDX_W      = $clog2(N_PORTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS*WIDTH-1:0]   s_axis_data,
    input  logic [N_PORTS-1:0]         s_axis_valid,
    input  logic [N_PORTS-1:0]         s_axis_last,
    output logic [N_PORTS-1:0]         s_axis_ready,
    output logic [WIDTH-1:0]           m_axis_data,
    output logic                       m_axis_valid,
    output logic                       m_axis_last,
    input  logic                       m_axis_ready,
    output logic                       grant_active,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       burst_cut
);

    localparam int unsigned CNT_W          = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam int unsigned BURST_LAST_INT = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;
    localparam logic [CNT_W-1:0] BurstLast = CNT_W'(BURST_LAST_INT);
    localparam logic [IDX_W-1:0] LastPort  = IDX_W'(N_PORTS - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             burst_cut_q, burst_cut_d;

    logic [WIDTH-1:0] port_data [N_PORTS];

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
        assign port_data[gi] = s_axis_data[gi*WIDTH +: WIDTH];
    end

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
    logic             any_req;
    logic             hit_hi;
    logic [IDX_W-1:0] pick_hi;
    logic [IDX_W-1:0] pick_lo;
    logic [IDX_W-1:0] pick_idx;

    assign any_req = |s_axis_valid;

    always_comb begin
        hit_hi  = 1'b0;
        pick_hi = '0;
        pick_lo = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (s_axis_valid[i]) begin
                pick_lo = IDX_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hit_hi  = 1'b1;
                    pick_hi = IDX_W'(i);
                end
            end
        end
        pick_idx = hit_hi ? pick_hi : pick_lo;
    end

    logic [IDX_W-1:0] next_ptr;
    logic             beat_acc;

    assign next_ptr = (grant_idx_q == LastPort) ? '0 : grant_idx_q + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_idx_d  = grant_idx_q;
        beat_cnt_d   = beat_cnt_q;
        burst_cut_d  = 1'b0;
        s_axis_ready = '0;
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        beat_acc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_idx_d = pick_idx;
                    state_d     = StGrant;
                end
            end
            StGrant: begin
                m_axis_data               = port_data[grant_idx_q];
                m_axis_valid              = s_axis_valid[grant_idx_q];
                m_axis_last               = s_axis_last[grant_idx_q];
                s_axis_ready[grant_idx_q] = m_axis_ready;
                beat_acc                  = s_axis_valid[grant_idx_q] && m_axis_ready;
                if (beat_acc) begin
                    if (s_axis_last[grant_idx_q]) begin
                        state_d    = StIdle;
                        rr_ptr_d   = next_ptr;
                        beat_cnt_d = '0;
                    end else if (MAX_BURST != 0 && beat_cnt_q == BurstLast) begin
                        // Forced release; the rest of the packet re-arbitrates later.
                        state_d     = StIdle;
                        rr_ptr_d    = next_ptr;
                        beat_cnt_d  = '0;
                        burst_cut_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            beat_cnt_q  <= '0;
            burst_cut_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cut_q <= burst_cut_d;
        end
    end

    assign grant_active = (state_q == StGrant);
    assign grant_idx    = grant_idx_q;
    assign burst_cut    = burst_cut_q;

endmodule
